// File: rtl/e203_exu_alu_dpsh_arb.sv
// Arbiter that shares the single EXU adder/comparator datapath between several
// requesters (ALU, BJP, AGU, MDV). Round-robin selection in IDLE, an accepted
// step with req_lock set pins the datapath to that requester until it issues
// a step without lock. The datapath result is captured into a one-entry
// buffer and returned to its owner with valid/ready backpressure.
module e203_exu_alu_dpsh_arb #(
    parameter int NREQ = 4,
    parameter int OPW  = 32,
    parameter int CMDW = 8,
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*CMDW-1:0] req_cmd,
    input  logic [NREQ*OPW-1:0]  req_op1,
    input  logic [NREQ*OPW-1:0]  req_op2,
    output logic                 dp_valid,
    output logic [CMDW-1:0]      dp_cmd,
    output logic [OPW-1:0]       dp_op1,
    output logic [OPW-1:0]       dp_op2,
    input  logic [OPW-1:0]       dp_res,
    input  logic                 dp_cmp,
    output logic [NREQ-1:0]      res_valid,
    input  logic [NREQ-1:0]      res_ready,
    output logic [OPW-1:0]       res_data,
    output logic                 res_cmp,
    output logic                 lock_active,
    output logic [PTRW-1:0]      lock_owner
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // Decode a requester index into its one-hot position.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [PTRW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = {NREQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Advance a requester index by one, wrapping at NREQ-1 even when NREQ is
    // not a power of two.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        logic [PTRW-1:0] n;
        if (p == PTRW'(NREQ - 1)) begin
            n = {PTRW{1'b0}};
        end else begin
            n = p + PTRW'(1);
        end
        return n;
    endfunction

    state_e          state_r;
    state_e          state_nxt_s;
    logic [PTRW-1:0] rr_ptr_r;
    logic [PTRW-1:0] rr_ptr_nxt_s;
    logic [PTRW-1:0] lock_owner_r;
    logic [PTRW-1:0] lock_owner_nxt_s;

    logic            res_vld_r;
    logic [PTRW-1:0] res_own_r;
    logic [OPW-1:0]  res_data_r;
    logic            res_cmp_r;

    logic            buf_free_s;
    logic            grant_vld_s;
    logic [PTRW-1:0] grant_idx_s;
    logic            hs_s;

    // The buffer can take a new result when empty or when its current owner
    // drains it this very cycle.
    assign buf_free_s = ~res_vld_r | res_ready[res_own_r];

    // Select the candidate requester: lock owner only while locked, otherwise
    // the first valid requester at or after the round-robin pointer.
    always_comb begin
        logic [PTRW-1:0] cand;
        logic            hit;
        grant_vld_s = 1'b0;
        grant_idx_s = {PTRW{1'b0}};
        cand        = {PTRW{1'b0}};
        hit         = 1'b0;
        if (state_r == ST_LOCK) begin
            grant_vld_s = req_valid[lock_owner_r];
            grant_idx_s = lock_owner_r;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand        = PTRW'((int'(rr_ptr_r) + k) % NREQ);
                hit         = req_valid[cand] & ~grant_vld_s;
                grant_idx_s = hit ? cand : grant_idx_s;
                grant_vld_s = grant_vld_s | hit;
            end
        end
    end

    // A step is accepted only outside reset and when the result buffer has room.
    assign hs_s = grant_vld_s & buf_free_s & ~rst;

    // Arbiter state, round-robin pointer and lock owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {PTRW{1'b0}};
            lock_owner_r <= {PTRW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            lock_owner_r <= lock_owner_nxt_s;
        end
    end

    // Next-state logic: lock entry/exit and pointer advance on accepted steps.
    always_comb begin
        state_nxt_s      = state_r;
        rr_ptr_nxt_s     = rr_ptr_r;
        lock_owner_nxt_s = lock_owner_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s && req_lock[grant_idx_s]) begin
                    state_nxt_s      = ST_LOCK;
                    lock_owner_nxt_s = grant_idx_s;
                end else if (hs_s) begin
                    rr_ptr_nxt_s     = ptr_inc(grant_idx_s);
                end else begin
                    state_nxt_s      = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (hs_s && !req_lock[grant_idx_s]) begin
                    state_nxt_s      = ST_IDLE;
                    rr_ptr_nxt_s     = ptr_inc(lock_owner_r);
                    lock_owner_nxt_s = {PTRW{1'b0}};
                end else begin
                    state_nxt_s      = ST_LOCK;
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                rr_ptr_nxt_s     = {PTRW{1'b0}};
                lock_owner_nxt_s = {PTRW{1'b0}};
            end
        endcase
    end

    // Output logic: handshake, datapath operand mux and result/lock status.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        dp_valid  = 1'b0;
        dp_cmd    = {CMDW{1'b0}};
        dp_op1    = {OPW{1'b0}};
        dp_op2    = {OPW{1'b0}};
        if (hs_s) begin
            req_ready = idx_to_onehot(grant_idx_s);
            dp_valid  = 1'b1;
            dp_cmd    = req_cmd[int'(grant_idx_s)*CMDW +: CMDW];
            dp_op1    = req_op1[int'(grant_idx_s)*OPW +: OPW];
            dp_op2    = req_op2[int'(grant_idx_s)*OPW +: OPW];
        end else begin
            req_ready = {NREQ{1'b0}};
        end
        res_valid   = res_vld_r ? idx_to_onehot(res_own_r) : {NREQ{1'b0}};
        res_data    = res_data_r;
        res_cmp     = res_cmp_r;
        lock_active = (state_r == ST_LOCK);
        lock_owner  = lock_owner_r;
    end

    // One-entry result buffer: load on accepted step, clear when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld_r  <= 1'b0;
            res_own_r  <= {PTRW{1'b0}};
            res_data_r <= {OPW{1'b0}};
            res_cmp_r  <= 1'b0;
        end else if (hs_s) begin
            res_vld_r  <= 1'b1;
            res_own_r  <= grant_idx_s;
            res_data_r <= dp_res;
            res_cmp_r  <= dp_cmp;
        end else if (res_vld_r && res_ready[res_own_r]) begin
            res_vld_r  <= 1'b0;
        end else begin
            res_vld_r  <= res_vld_r;
        end
    end

endmodule

// File: tb/tb_e203_exu_alu_dpsh_arb.sv
// Directed bench for the shared-datapath arbiter. The bench plays the role of
// the adder/comparator, drives hand-planned request patterns, checks grants
// cycle by cycle and uses a scoreboard queue for returned results.
module tb_e203_exu_alu_dpsh_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [3:0]   req_lock;
    logic [31:0]  req_cmd;
    logic [127:0] req_op1;
    logic [127:0] req_op2;
    logic         dp_valid;
    logic [7:0]   dp_cmd;
    logic [31:0]  dp_op1;
    logic [31:0]  dp_op2;
    logic [31:0]  dp_res;
    logic         dp_cmp;
    logic [3:0]   res_valid;
    logic [3:0]   res_ready;
    logic [31:0]  res_data;
    logic         res_cmp;
    logic         lock_active;
    logic [1:0]   lock_owner;

    logic [31:0]  op1_a [4];
    logic [31:0]  op2_a [4];
    logic [7:0]   cmd_a [4];

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] data;
        logic        cmp;
    } sb_t;

    sb_t sb_q[$];
    int  checks;
    int  failures;

    e203_exu_alu_dpsh_arb #(.NREQ(4), .OPW(32), .CMDW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_lock    (req_lock),
        .req_cmd     (req_cmd),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .dp_valid    (dp_valid),
        .dp_cmd      (dp_cmd),
        .dp_op1      (dp_op1),
        .dp_op2      (dp_op2),
        .dp_res      (dp_res),
        .dp_cmp      (dp_cmp),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_cmp     (res_cmp),
        .lock_active (lock_active),
        .lock_owner  (lock_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench model of the shared datapath: add with the command folded in, unsigned less-than.
    assign dp_res = dp_op1 + dp_op2 + {24'd0, dp_cmd};
    assign dp_cmp = (dp_op1 < dp_op2);

    // Pack per-requester fields onto the flat request buses.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_cmd[i*8 +: 8]   = cmd_a[i];
            req_op1[i*32 +: 32] = op1_a[i];
            req_op2[i*32 +: 32] = op2_a[i];
        end
    end

    function automatic logic [31:0] exp_res(input int g);
        return op1_a[g] + op2_a[g] + {24'd0, cmd_a[g]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One bench cycle: drive inputs at the falling edge, check grant-side
    // outputs, and queue the expected result if a handshake is planned.
    task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] lk,
                       input logic [3:0] rr, input logic [3:0] exp_rdy,
                       input logic exp_la, input logic [1:0] exp_own, input string nm);
        int  g;
        sb_t e;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_lock  = lk;
        res_ready = rr;
        if (r) sb_q.delete();
        #1;
        chk({nm, ":req_ready"},  req_ready,   exp_rdy);
        chk({nm, ":dp_valid"},   dp_valid,    exp_rdy != 4'b0000);
        chk({nm, ":lock_active"}, lock_active, exp_la);
        chk({nm, ":lock_owner"}, lock_owner,  exp_own);
        if (exp_rdy != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) g = i;
            chk({nm, ":dp_op1"}, dp_op1, op1_a[g]);
            chk({nm, ":dp_cmd"}, dp_cmd, cmd_a[g]);
            e.own  = 2'(g);
            e.data = exp_res(g);
            e.cmp  = (op1_a[g] < op2_a[g]);
            sb_q.push_back(e);
        end else begin
            chk({nm, ":dp_op1_idle"}, dp_op1, 32'd0);
            chk({nm, ":dp_cmd_idle"}, dp_cmd, 8'd0);
        end
    endtask

    // Monitor: whenever a result is presented and accepted, compare it with the
    // oldest queued expectation.
    always @(negedge clk) begin
        sb_t e;
        #2;
        if (!rst && ((res_valid & res_ready) != 4'b0000)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", res_valid, 4'b0000);
            end else begin
                e = sb_q.pop_front();
                chk("sb_res_valid", res_valid, 4'b0001 << e.own);
                chk("sb_res_data",  res_data,  e.data);
                chk("sb_res_cmp",   res_cmp,   e.cmp);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        res_ready = 4'b0000;
        op1_a[0] = 32'd10;         op2_a[0] = 32'd20;         cmd_a[0] = 8'h01;
        op1_a[1] = 32'hFFFF_FFF0;  op2_a[1] = 32'h0000_0020;  cmd_a[1] = 8'h02;
        op1_a[2] = 32'h1234_5678;  op2_a[2] = 32'h1111_1111;  cmd_a[2] = 8'h04;
        op1_a[3] = 32'd100;        op2_a[3] = 32'd200;        cmd_a[3] = 8'h08;

        // Reset held two cycles with every requester asking
        cyc(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "t1_rst0");
        chk("t1_res_valid0", res_valid, 4'b0000);
        cyc(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "t1_rst1");
        chk("t1_res_valid1", res_valid, 4'b0000);
        chk("t1_res_data",   res_data,  32'd0);

        // Round robin with all requesters valid and results always accepted
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0001, 1'b0, 2'd0, "t2_g0");
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0010, 1'b0, 2'd0, "t2_g1");
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0100, 1'b0, 2'd0, "t2_g2");
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1000, 1'b0, 2'd0, "t2_g3");
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0001, 1'b0, 2'd0, "t2_g0w");
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0010, 1'b0, 2'd0, "t2_g1b");

        // Requester 3 locks for three steps while 0 and 1 keep asking
        op1_a[3] = 32'd5;
        op2_a[3] = 32'd7;
        cyc(1'b0, 4'b1011, 4'b1000, 4'b1111, 4'b1000, 1'b0, 2'd0, "t3_s1");
        cyc(1'b0, 4'b1011, 4'b1000, 4'b1111, 4'b1000, 1'b1, 2'd3, "t3_s2");
        cyc(1'b0, 4'b1011, 4'b1000, 4'b1111, 4'b1000, 1'b1, 2'd3, "t3_s3");
        cyc(1'b0, 4'b1011, 4'b0000, 4'b1111, 4'b1000, 1'b1, 2'd3, "t3_s4");
        cyc(1'b0, 4'b0011, 4'b0000, 4'b1111, 4'b0001, 1'b0, 2'd0, "t3_after");

        // Backpressure: requester 1 result held while requester 2 waits
        cyc(1'b0, 4'b0010, 4'b0000, 4'b1111, 4'b0010, 1'b0, 2'd0, "t4_g1");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'b0100, 4'b0000, 4'b1101, 4'b0000, 1'b0, 2'd0, "t4_stall");
            chk("t4_res_valid", res_valid, 4'b0010);
            chk("t4_res_data",  res_data,  exp_res(1));
        end
        cyc(1'b0, 4'b0100, 4'b0000, 4'b1111, 4'b0100, 1'b0, 2'd0, "t4_g2");

        // Reset while locked with a result buffered
        cyc(1'b0, 4'b0100, 4'b0100, 4'b1111, 4'b0100, 1'b0, 2'd0, "t5_lock");
        cyc(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, "t5_full");
        chk("t5_res_valid_full", res_valid, 4'b0100);
        cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, "t5_rst");
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0001, 1'b0, 2'd0, "t5_after");
        chk("t5_res_valid_after", res_valid, 4'b0000);

        // Lock owner goes quiet; requester 0 must wait
        cyc(1'b0, 4'b0011, 4'b0010, 4'b1111, 4'b0010, 1'b0, 2'd0, "t6_lock");
        cyc(1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 1'b1, 2'd1, "t6_idle0");
        cyc(1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 1'b1, 2'd1, "t6_idle1");
        cyc(1'b0, 4'b0011, 4'b0000, 4'b1111, 4'b0010, 1'b1, 2'd1, "t6_unlock");
        cyc(1'b0, 4'b0001, 4'b0000, 4'b1111, 4'b0001, 1'b0, 2'd0, "t6_g0");
        cyc(1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, "drain0");
        cyc(1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, "drain1");
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
